// File: rtl/mccu_pkg.sv
// Shared types and helpers for the MCCU quota engine: per-core state encoding,
// consumption-sum width and the default quota word.
package mccu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_EXHAUSTED = 2'd2
  } core_state_e;

  // Width of the per-core event-weight sum, wide enough to never overflow
  function automatic int cons_width(input int weight_width, input int events_per_core);
    return weight_width + $clog2(events_per_core);
  endfunction

  localparam int QUOTA_WIDTH = 32;
  typedef logic [QUOTA_WIDTH-1:0] quota_t;

endpackage

// File: rtl/mccu_core_quota.sv
// One quota channel: weighted event sum, saturating decrement, IDLE/RUN/EXHAUSTED
// state and the registered level interrupt.
module mccu_core_quota
  import mccu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int EVENTS_PER_CORE = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rstn_i,
  input  logic                                         enable_i,
  input  logic                                         update_i,
  input  logic                                         refill_i,
  input  logic [DATA_WIDTH-1:0]                        limit_i,
  input  logic [EVENTS_PER_CORE-1:0][WEIGHT_WIDTH-1:0] weights_i,
  input  logic [EVENTS_PER_CORE-1:0]                   events_i,
  output logic [DATA_WIDTH-1:0]                        quota_o,
  output logic                                         intr_o
);

  localparam int CONS_WIDTH = cons_width(WEIGHT_WIDTH, EVENTS_PER_CORE);

  core_state_e            state_r, state_s;
  logic [DATA_WIDTH-1:0]  quota_r, quota_s;
  logic                   intr_r, intr_s;
  logic [CONS_WIDTH-1:0]  cons_s;
  logic [DATA_WIDTH-1:0]  cons_ext_s;
  logic [DATA_WIDTH-1:0]  sub_s;
  logic                   limit_nz_s;

  // Sum of weights over the events asserted this cycle
  always_comb begin
    cons_s = {CONS_WIDTH{1'b0}};
    for (int e = 0; e < EVENTS_PER_CORE; e++) begin
      if (events_i[e]) begin
        cons_s = cons_s + CONS_WIDTH'(weights_i[e]);
      end else begin
        cons_s = cons_s;
      end
    end
  end

  assign cons_ext_s = DATA_WIDTH'(cons_s);
  assign sub_s      = (quota_r > cons_ext_s) ? (quota_r - cons_ext_s) : {DATA_WIDTH{1'b0}};
  assign limit_nz_s = (limit_i != {DATA_WIDTH{1'b0}});

  // Next state: update > refill > hold when disabled > event decrement
  always_comb begin
    state_s = state_r;
    quota_s = quota_r;
    intr_s  = intr_r;
    if (update_i) begin
      quota_s = limit_i;
      state_s = limit_nz_s ? ST_RUN : ST_EXHAUSTED;
      intr_s  = ~limit_nz_s;
    end else if (refill_i) begin
      if (state_r != ST_IDLE) begin
        quota_s = limit_i;
        state_s = limit_nz_s ? ST_RUN : ST_EXHAUSTED;
        intr_s  = ~limit_nz_s;
      end else begin
        state_s = state_r;
      end
    end else if (!enable_i) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          quota_s = sub_s;
          if (sub_s == {DATA_WIDTH{1'b0}}) begin
            state_s = ST_EXHAUSTED;
            intr_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_IDLE, ST_EXHAUSTED: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
          quota_s = {DATA_WIDTH{1'b0}};
          intr_s  = 1'b0;
        end
      endcase
    end
  end

  // State, quota and interrupt registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
      quota_r <= {DATA_WIDTH{1'b0}};
      intr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      quota_r <= quota_s;
      intr_r  <= intr_s;
    end
  end

  assign quota_o = quota_r;
  assign intr_o  = intr_r;

endmodule

// File: rtl/mccu_quota_engine.sv
// Weighted per-core contention quota engine with optional periodic refill;
// the top owns only the refill counter and replicates the per-core channel.
module mccu_quota_engine
  import mccu_pkg::*;
#(
  parameter int N_CORES         = 4,
  parameter int EVENTS_PER_CORE = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int PERIOD_WIDTH    = 32
) (
  input  logic                                                 clk_i,
  input  logic                                                 rstn_i,
  input  logic                                                 enable_i,
  input  logic                                                 update_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0]                   quota_limit_i,
  input  logic [N_CORES*EVENTS_PER_CORE-1:0][WEIGHT_WIDTH-1:0] weights_i,
  input  logic [N_CORES*EVENTS_PER_CORE-1:0]                   events_i,
  input  logic [PERIOD_WIDTH-1:0]                              refill_period_i,
  output logic [N_CORES-1:0][DATA_WIDTH-1:0]                   quota_o,
  output logic [N_CORES-1:0]                                   intr_o
);

  logic [PERIOD_WIDTH-1:0] cnt_r, cnt_s;
  logic                    period_on_s;
  logic                    match_s;
  logic                    refill_s;

  assign period_on_s = (refill_period_i != {PERIOD_WIDTH{1'b0}});
  // Counter may sit above a freshly lowered period; it then wraps naturally before matching
  assign match_s     = (cnt_r == (refill_period_i - {{(PERIOD_WIDTH-1){1'b0}}, 1'b1}));
  assign refill_s    = enable_i & period_on_s & match_s;

  // Refill counter next value
  always_comb begin
    cnt_s = cnt_r;
    if (update_i) begin
      cnt_s = {PERIOD_WIDTH{1'b0}};
    end else if (refill_s) begin
      cnt_s = {PERIOD_WIDTH{1'b0}};
    end else if (enable_i && period_on_s) begin
      cnt_s = cnt_r + {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Refill counter register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_r <= {PERIOD_WIDTH{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    mccu_core_quota #(
      .DATA_WIDTH      (DATA_WIDTH),
      .WEIGHT_WIDTH    (WEIGHT_WIDTH),
      .EVENTS_PER_CORE (EVENTS_PER_CORE)
    ) u_core (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .enable_i  (enable_i),
      .update_i  (update_i),
      .refill_i  (refill_s),
      .limit_i   (quota_limit_i[c]),
      .weights_i (weights_i[c*EVENTS_PER_CORE +: EVENTS_PER_CORE]),
      .events_i  (events_i[c*EVENTS_PER_CORE +: EVENTS_PER_CORE]),
      .quota_o   (quota_o[c]),
      .intr_o    (intr_o[c])
    );
  end

endmodule

// File: tb/tb_mccu_quota_engine.sv
// Scoreboard bench for mccu_quota_engine: directed scenarios plus random traffic
// checked against a rule-level reference model.
module tb_mccu_quota_engine;

  localparam int NC  = 4;
  localparam int EPC = 2;
  localparam int DW  = 32;
  localparam int WW  = 8;
  localparam int PW  = 32;
  localparam longint unsigned WRAP = 64'h1_0000_0000;

  logic                          clk_i = 1'b0;
  logic                          rstn_i;
  logic                          enable_i;
  logic                          update_i;
  logic [NC-1:0][DW-1:0]         quota_limit_i;
  logic [NC*EPC-1:0][WW-1:0]     weights_i;
  logic [NC*EPC-1:0]             events_i;
  logic [PW-1:0]                 refill_period_i;
  logic [NC-1:0][DW-1:0]         quota_o;
  logic [NC-1:0]                 intr_o;

  mccu_quota_engine #(
    .N_CORES(NC), .EVENTS_PER_CORE(EPC), .DATA_WIDTH(DW),
    .WEIGHT_WIDTH(WW), .PERIOD_WIDTH(PW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .update_i(update_i),
    .quota_limit_i(quota_limit_i), .weights_i(weights_i), .events_i(events_i),
    .refill_period_i(refill_period_i), .quota_o(quota_o), .intr_o(intr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NC-1:0][DW-1:0] q;
    logic [NC-1:0]         intr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference model: remaining budget, loaded-since-reset and exhausted flags, refill counter
  longint unsigned m_q[NC];
  bit              m_act[NC];
  bit              m_exh[NC];
  longint unsigned m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_q[c] = 0; m_act[c] = 0; m_exh[c] = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void load_core(int c);
    m_q[c]   = quota_limit_i[c];
    m_act[c] = 1;
    m_exh[c] = (quota_limit_i[c] == 0);
  endfunction

  function automatic void model_step();
    longint unsigned per = refill_period_i;
    longint unsigned cons;
    if (update_i) begin
      for (int c = 0; c < NC; c++) load_core(c);
      m_cnt = 0;
    end else if (enable_i && per != 0 && m_cnt == per - 1) begin
      m_cnt = 0;
      for (int c = 0; c < NC; c++) if (m_act[c]) load_core(c);
    end else if (enable_i) begin
      if (per != 0) m_cnt = (m_cnt + 1) % WRAP;
      for (int c = 0; c < NC; c++) begin
        if (m_act[c] && !m_exh[c]) begin
          cons = 0;
          for (int e = 0; e < EPC; e++)
            if (events_i[c*EPC+e]) cons += weights_i[c*EPC+e];
          m_q[c] = (m_q[c] > cons) ? m_q[c] - cons : 0;
          if (m_q[c] == 0) m_exh[c] = 1;
        end
      end
    end
  endfunction

  // Apply one clock of the current inputs: model predicts, scoreboard receives
  task automatic step();
    exp_t e;
    model_step();
    for (int c = 0; c < NC; c++) begin
      e.q[c]    = m_q[c][DW-1:0];
      e.intr[c] = m_act[c] && m_exh[c];
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic async_reset();
    rstn_i = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      check($sformatf("reset_quota[%0d]", c), quota_o[c], 64'd0);
      check($sformatf("reset_intr[%0d]", c), intr_o[c], 64'd0);
    end
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  // Monitor: compare every output cycle against the oldest prediction
  always @(posedge clk_i) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int c = 0; c < NC; c++) begin
        check($sformatf("quota[%0d]", c), quota_o[c], mon_e.q[c]);
        check($sformatf("intr[%0d]", c), intr_o[c], mon_e.intr[c]);
      end
    end
  end

  initial begin
    rstn_i = 1'b0; enable_i = 1'b1; update_i = 1'b0;
    quota_limit_i = '0; weights_i = '0; events_i = '0; refill_period_i = '0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("init_quota[%0d]", c), quota_o[c], 64'd0);
      check($sformatf("init_intr[%0d]", c), intr_o[c], 64'd0);
    end
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Limit 100, weights 1+2 for ten cycles
    quota_limit_i[0] = 32'd100; weights_i[0] = 8'd1; weights_i[1] = 8'd2;
    update_i = 1'b1; step(); update_i = 1'b0;
    events_i = 8'h03;
    repeat (10) step();
    check("plan_quota0_70", quota_o[0], 64'd70);
    check("plan_intr0_low", intr_o[0], 64'd0);
    check("plan_intr1_zero_limit", intr_o[1], 64'd1);

    // Limit 5, weight 3 held: 5, 2, 0 then interrupt holds
    quota_limit_i[1] = 32'd5; weights_i[2] = 8'd3; events_i = 8'h00;
    update_i = 1'b1; step(); update_i = 1'b0;
    events_i = 8'h04;
    repeat (22) step();
    check("exhaust_quota1", quota_o[1], 64'd0);
    check("exhaust_intr1", intr_o[1], 64'd1);

    // Period 8 refill, limit 10, weight 1
    for (int c = 0; c < NC; c++) begin
      quota_limit_i[c] = 32'd10; weights_i[c*EPC] = 8'd1; weights_i[c*EPC+1] = 8'd0;
    end
    events_i = 8'h55; refill_period_i = 32'd8;
    update_i = 1'b1; step(); update_i = 1'b0;
    repeat (40) step();
    check("refill_no_intr", intr_o, 64'd0);

    // Update with simultaneous heavy events
    quota_limit_i[0] = 32'd40; weights_i[0] = 8'd50; events_i = 8'h01;
    update_i = 1'b1; step(); update_i = 1'b0;
    check("update_wins_quota", quota_o[0], 64'd40);
    check("update_wins_intr", intr_o[0], 64'd0);

    // Freeze, then asynchronous reset mid-run
    weights_i[0] = 8'd1; events_i = 8'hFF; enable_i = 1'b0;
    repeat (6) step();
    enable_i = 1'b1;
    repeat (5) step();
    async_reset();
    repeat (5) step();
    check("post_reset_no_intr", intr_o, 64'd0);
    check("post_reset_quota0", quota_o[0], 64'd0);

    // Saturation with 255+255 against 500, then refill restores
    quota_limit_i[0] = 32'd500; weights_i[0] = 8'd255; weights_i[1] = 8'd255;
    events_i = 8'h03; refill_period_i = 32'd8;
    update_i = 1'b1; step(); update_i = 1'b0;
    step();
    check("sat_quota0", quota_o[0], 64'd0);
    check("sat_intr0", intr_o[0], 64'd1);
    repeat (7) step();
    check("sat_refill_quota0", quota_o[0], 64'd500);
    check("sat_refill_intr0", intr_o[0], 64'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0)
        for (int c = 0; c < NC; c++)
          quota_limit_i[c] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
      if ($urandom_range(0, 29) == 0)
        for (int k = 0; k < NC*EPC; k++)
          weights_i[k] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 5))
          0: refill_period_i = 32'd0;
          1: refill_period_i = 32'd1;
          2: refill_period_i = 32'd2;
          3: refill_period_i = 32'd5;
          4: refill_period_i = 32'd13;
          default: refill_period_i = 32'd40;
        endcase
      end
      events_i = 8'($urandom);
      enable_i = ($urandom_range(0, 9) != 0);
      update_i = ($urandom_range(0, 39) == 0);
      step();
    end
    update_i = 1'b0;
    @(negedge clk_i);
    check("scoreboard_drained", exp_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
